// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Purpose : Shared types and helpers for the sprite renderer slice.
//   coord_t      - 10-bit screen coordinate
//   SCREEN_W/H   - visible raster size
//   sprite_req_t - position/visibility record used for the shadow and active
//                  registers (carries hflip when SPRITE_HFLIP_EN is defined)
//   width_of()   - bit width needed to count 0..n-1 (never less than 1)
// Configuration macro: SPRITE_HFLIP_EN (adds the hflip field)
// -----------------------------------------------------------------------------
package sprite_pkg;

    typedef logic [9:0] coord_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef struct packed {
        coord_t x;
        coord_t y;
        logic   show;
`ifdef SPRITE_HFLIP_EN
        logic   hflip;
`endif
    } sprite_req_t;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_renderer_anim_ctr.sv
// -----------------------------------------------------------------------------
// sprite_anim_ctr
// Purpose : Animation frame counter. Every ANIM_DIV enabled frame_start pulses
//           advance frame_idx by one, wrapping FRAMES-1 -> 0. Because it only
//           moves on frame_start, frame_idx is stable across a visible frame.
// Ports   :
//   vga_clk     in   pixel clock
//   reset       in   asynchronous, active-high
//   frame_start in   one-cycle pulse at start of vertical blank
//   anim_en     in   advance enable (0 freezes divider and frame index)
//   frame_idx   out  current animation frame
// -----------------------------------------------------------------------------
module sprite_anim_ctr
    import sprite_pkg::*;
#(
    parameter int FRAMES   = 4,
    parameter int ANIM_DIV = 8,
    parameter int FIDX_W   = width_of(FRAMES)
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              anim_en,
    output logic [FIDX_W-1:0] frame_idx
);

    localparam int DIV_W = width_of(ANIM_DIV);

    logic [DIV_W-1:0]  r_div;
    logic [FIDX_W-1:0] r_frame;

    // Divider and frame index, both advancing only on enabled frame_start.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_div   <= '0;
            r_frame <= '0;
        end else if (frame_start && anim_en) begin
            if (r_div == DIV_W'(ANIM_DIV - 1)) begin
                r_div   <= '0;
                r_frame <= (r_frame == FIDX_W'(FRAMES - 1)) ? '0 : r_frame + FIDX_W'(1);
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    assign frame_idx = r_frame;

endmodule

// File: rtl/sprite_renderer.sv
// -----------------------------------------------------------------------------
// sprite_renderer
// Purpose : Sprite pixel generator for the VGA path. Places an SPR_W x SPR_H
//           sprite at a runtime position with 2**SCALE_LOG2 scaling and
//           multi-frame animation, drives a synchronous sprite ROM and emits
//           palette index + opaque flag 3 cycles after DrawX/DrawY.
// Ports   :
//   vga_clk, reset          clock / async active-high reset
//   DrawX, DrawY            current raster position
//   frame_start             pulse at start of vertical blank
//   pos_x, pos_y, show_in   position request (valid/ready into shadow reg)
//   pos_valid / pos_ready   request handshake; ready = shadow empty
//   hflip_in                mirror request (only with SPRITE_HFLIP_EN)
//   anim_en                 animation advance enable
//   rom_addr / rom_q        sprite ROM address / data (1-cycle latency)
//   pix_index, pix_on       palette index and opaque flag
// Configuration macro: SPRITE_HFLIP_EN (horizontal mirroring)
// -----------------------------------------------------------------------------
module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int SPR_W      = 16,
    parameter int SPR_H      = 16,
    parameter int FRAMES     = 4,
    parameter int SCALE_LOG2 = 1,
    parameter int IDX_W      = 2,
    parameter int TRANSP_IDX = 0,
    parameter int ANIM_DIV   = 8,
    parameter int ADDR_W     = $clog2(FRAMES * SPR_W * SPR_H)
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              frame_start,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              show_in,
    input  logic              pos_valid,
    output logic              pos_ready,
`ifdef SPRITE_HFLIP_EN
    input  logic              hflip_in,
`endif
    input  logic              anim_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pix_index,
    output logic              pix_on
);

    localparam int FIDX_W = width_of(FRAMES);
    localparam int COL_W  = width_of(SPR_W);
    localparam int ROW_W  = width_of(SPR_H);
    localparam int BOX_W  = SPR_W << SCALE_LOG2;
    localparam int BOX_H  = SPR_H << SCALE_LOG2;

    sprite_req_t       w_req;
    sprite_req_t       r_shadow;
    sprite_req_t       r_active;
    logic              r_shadow_full;
    logic [FIDX_W-1:0] w_frame_idx;
    logic [10:0]       w_dx;
    logic [10:0]       w_dy;
    logic              w_in_box;
    logic [COL_W-1:0]  w_col_raw;
    logic [COL_W-1:0]  w_col;
    logic [ROW_W-1:0]  w_row;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_v1;
    logic              r_v2;
    logic [IDX_W-1:0]  r_pix_index;
    logic              r_pix_on;

    sprite_anim_ctr #(
        .FRAMES   (FRAMES),
        .ANIM_DIV (ANIM_DIV),
        .FIDX_W   (FIDX_W)
    ) u_anim (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .frame_start (frame_start),
        .anim_en     (anim_en),
        .frame_idx   (w_frame_idx)
    );

    // Pack the incoming request into the shared record layout.
    always_comb begin
        w_req      = '0;
        w_req.x    = pos_x;
        w_req.y    = pos_y;
        w_req.show = show_in;
`ifdef SPRITE_HFLIP_EN
        w_req.hflip = hflip_in;
`endif
    end

    // Shadow capture and frame-boundary commit. Commit needs a full shadow and
    // capture needs an empty one, so a request arriving with frame_start waits
    // for the next frame_start.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_shadow      <= '0;
            r_active      <= '0;
            r_shadow_full <= 1'b0;
        end else if (frame_start && r_shadow_full) begin
            r_active      <= r_shadow;
            r_shadow_full <= 1'b0;
        end else if (pos_valid && !r_shadow_full) begin
            r_shadow      <= w_req;
            r_shadow_full <= 1'b1;
        end
    end

    assign pos_ready = ~r_shadow_full;

    // 11-bit differences: bit 10 set means the raster is left of / above the box.
    assign w_dx      = {1'b0, DrawX} - {1'b0, r_active.x};
    assign w_dy      = {1'b0, DrawY} - {1'b0, r_active.y};
    assign w_in_box  = !w_dx[10] && (w_dx < 11'(BOX_W)) &&
                       !w_dy[10] && (w_dy < 11'(BOX_H));
    assign w_col_raw = COL_W'(w_dx >> SCALE_LOG2);
    assign w_row     = ROW_W'(w_dy >> SCALE_LOG2);

    // Texel column, mirrored when the active record requests it.
    always_comb begin
        w_col = w_col_raw;
`ifdef SPRITE_HFLIP_EN
        if (r_active.hflip) begin
            w_col = COL_W'(SPR_W - 1) - w_col_raw;
        end else begin
            w_col = w_col_raw;
        end
`endif
    end

    assign w_addr = ADDR_W'(w_frame_idx) * ADDR_W'(SPR_W * SPR_H) +
                    ADDR_W'(w_row) * ADDR_W'(SPR_W) + ADDR_W'(w_col);

    // Three-stage pixel pipeline: address, ROM read, index/opaque decision.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_rom_addr  <= '0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_pix_index <= '0;
            r_pix_on    <= 1'b0;
        end else begin
            if (w_in_box) begin
                r_rom_addr <= w_addr;
            end
            r_v1        <= w_in_box && r_active.show;
            r_v2        <= r_v1;
            r_pix_index <= r_v2 ? rom_q : '0;
            r_pix_on    <= r_v2 && (rom_q != IDX_W'(TRANSP_IDX));
        end
    end

    assign rom_addr  = r_rom_addr;
    assign pix_index = r_pix_index;
    assign pix_on    = r_pix_on;

endmodule
